// File: rtl/tqvp_tacos_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tqvp_tacos_pkg : register map, access sizes and channel states
// Rev 1.0
// ----------------------------------------------------------------------------
package tqvp_tacos_pkg;

  localparam logic [5:0] c_CTRL      = 6'h00;
  localparam logic [5:0] c_IRQ_FLAG  = 6'h04;
  localparam logic [5:0] c_EN        = 6'h08;
  localparam logic [5:0] c_CH_BASE   = 6'h10;
  localparam logic [5:0] c_CH_STRIDE = 6'h08;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_IDLE = 2'b11
  } access_sz_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

  function automatic logic [31:0] size_mask(input access_sz_e sz);
    case (sz)
      SZ_BYTE: return 32'h0000_00FF;
      SZ_HALF: return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/tqvp_tacos_pwm_channel.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tqvp_tacos_pwm_channel : one double-buffered PWM counter channel
// Rev 1.0
// ----------------------------------------------------------------------------
module tqvp_tacos_pwm_channel
  import tqvp_tacos_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_tick,
  input  logic             i_enable,
  input  logic             i_oneshot,
  input  logic [CNT_W-1:0] i_period,
  input  logic [CNT_W-1:0] i_duty,
  output logic             o_pwm,
  output logic             o_wrap_pulse,
  output logic             o_oneshot_done
);

  ch_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_sper;
  logic [CNT_W-1:0] r_sduty;
  logic             r_pwm;
  logic             w_wrap;

  assign w_wrap         = (r_state == RUN) && i_enable && i_tick && (r_cnt == r_sper);
  assign o_wrap_pulse   = w_wrap;
  assign o_oneshot_done = w_wrap && i_oneshot;
  assign o_pwm          = r_pwm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sper  <= '0;
      r_sduty <= '0;
      r_pwm   <= 1'b0;
    end else begin
      // Gating with i_enable makes a global disable drop the output on the next edge
      r_pwm <= i_enable && (r_state == RUN) && (r_cnt < r_sduty);
      case (r_state)
        IDLE: begin
          r_cnt   <= '0;
          r_sper  <= i_period;
          r_sduty <= i_duty;
          if (i_enable) r_state <= RUN;
        end
        RUN: begin
          if (!i_enable) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (i_tick) begin
            if (r_cnt == r_sper) begin
              r_cnt   <= '0;
              r_sper  <= i_period;
              r_sduty <= i_duty;
              if (i_oneshot) r_state <= IDLE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/tqvp_tacos_pwm_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tqvp_tacos_pwm_timer : multi-channel PWM / compare timer on the TinyQV bus
// Rev 1.0
// ----------------------------------------------------------------------------
module tqvp_tacos_pwm_timer
  import tqvp_tacos_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  logic              r_gen;
  logic [7:0]        r_presc;
  logic [7:0]        r_pre;
  logic [NUM_CH-1:0] r_oneshot;
  logic [NUM_CH-1:0] r_irq_flag;
  logic [NUM_CH-1:0] r_ch_en;
  logic [NUM_CH-1:0] r_irq_en;

  logic [NUM_CH-1:0] w_pwm;
  logic [NUM_CH-1:0] w_wrap;
  logic [NUM_CH-1:0] w_done;
  logic [NUM_CH-1:0] w_clr;
  logic [31:0]       w_ch_img [NUM_CH];
  logic [31:0]       w_rd_img;
  logic [31:0]       w_mask;
  logic [31:0]       w_wnew;
  logic [5:0]        w_addr;
  access_sz_e        w_sz;
  logic              w_wr;
  logic              w_tick;
  logic              w_unused;

  assign w_addr = {address[5:2], 2'b00};
  assign w_sz   = access_sz_e'(data_write_n);
  assign w_wr   = (w_sz != SZ_IDLE);
  assign w_mask = size_mask(w_sz);
  // Partial writes merge into the current register image
  assign w_wnew = (w_rd_img & ~w_mask) | (data_in & w_mask);
  assign w_clr  = data_in[NUM_CH-1:0] & w_mask[NUM_CH-1:0];
  assign w_tick = r_gen && (r_pre == r_presc);

  assign uo_out         = 8'(w_pwm);
  assign data_out       = (data_read_n != 2'b11) ? w_rd_img : 32'h0;
  assign data_ready     = 1'b1;
  assign user_interrupt = |(r_irq_flag & r_irq_en);
  assign w_unused       = &{1'b0, ui_in, address[1:0], w_wnew};

  always_comb begin
    w_rd_img = '0;
    case (w_addr)
      c_CTRL: begin
        w_rd_img[0]           = r_gen;
        w_rd_img[15:8]        = r_presc;
        w_rd_img[16+:NUM_CH]  = r_oneshot;
      end
      c_IRQ_FLAG: w_rd_img[NUM_CH-1:0] = r_irq_flag;
      c_EN: begin
        w_rd_img[NUM_CH-1:0]  = r_ch_en;
        w_rd_img[8+:NUM_CH]   = r_irq_en;
      end
      default: for (int ch = 0; ch < NUM_CH; ch++) w_rd_img = w_rd_img | w_ch_img[ch];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
    end else if (!r_gen || (r_pre == r_presc)) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 8'd1;
    end
  end

  // Hardware flag set beats W1C; software CH_EN write beats one-shot clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gen      <= 1'b0;
      r_presc    <= '0;
      r_oneshot  <= '0;
      r_irq_flag <= '0;
      r_ch_en    <= '0;
      r_irq_en   <= '0;
    end else begin
      r_ch_en    <= r_ch_en & ~w_done;
      r_irq_flag <= r_irq_flag | w_wrap;
      if (w_wr) begin
        case (w_addr)
          c_CTRL: begin
            r_gen     <= w_wnew[0];
            r_presc   <= w_wnew[15:8];
            r_oneshot <= w_wnew[16+:NUM_CH];
          end
          c_IRQ_FLAG: r_irq_flag <= (r_irq_flag & ~w_clr) | w_wrap;
          c_EN: begin
            r_ch_en  <= w_wnew[NUM_CH-1:0];
            r_irq_en <= w_wnew[8+:NUM_CH];
          end
          default: ;
        endcase
      end
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    localparam logic [5:0] c_PER_ADDR  = 6'(c_CH_BASE + ch * c_CH_STRIDE);
    localparam logic [5:0] c_DUTY_ADDR = c_PER_ADDR + 6'd4;

    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_duty;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_period <= '0;
        r_duty   <= '0;
      end else if (w_wr) begin
        if (w_addr == c_PER_ADDR)  r_period <= w_wnew[CNT_W-1:0];
        if (w_addr == c_DUTY_ADDR) r_duty   <= w_wnew[CNT_W-1:0];
      end
    end

    assign w_ch_img[ch] = (w_addr == c_PER_ADDR)  ? 32'(r_period) :
                          (w_addr == c_DUTY_ADDR) ? 32'(r_duty)   : 32'h0;

    tqvp_tacos_pwm_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_tick         (w_tick),
      .i_enable       (r_gen & r_ch_en[ch]),
      .i_oneshot      (r_oneshot[ch]),
      .i_period       (r_period),
      .i_duty         (r_duty),
      .o_pwm          (w_pwm[ch]),
      .o_wrap_pulse   (w_wrap[ch]),
      .o_oneshot_done (w_done[ch])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_tqvp_tacos_pwm_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_tqvp_tacos_pwm_timer : scoreboard bench for the tacos PWM timer
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_tqvp_tacos_pwm_timer;

  localparam logic [1:0] SZB = 2'b00;
  localparam logic [1:0] SZH = 2'b01;
  localparam logic [1:0] SZW = 2'b10;

  logic        clk;
  logic        rst_n;
  logic [7:0]  ui_in;
  logic [7:0]  uo_out;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  tqvp_tacos_pwm_timer #(
    .NUM_CH (4),
    .CNT_W  (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ui_in          (ui_in),
    .uo_out         (uo_out),
    .address        (address),
    .data_in        (data_in),
    .data_write_n   (data_write_n),
    .data_read_n    (data_read_n),
    .data_out       (data_out),
    .data_ready     (data_ready),
    .user_interrupt (user_interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] act);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", 32'(sb_q.size()), 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check_val(e.tag, act, e.val);
  endtask

  // Bus tasks start and end on a falling edge
  task automatic bus_wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] sz);
    address      = a;
    data_in      = d;
    data_write_n = sz;
    @(negedge clk);
    data_write_n = 2'b11;
  endtask

  task automatic bus_rd(input logic [5:0] a, output logic [31:0] d, output logic rdy);
    address     = a;
    data_read_n = 2'b10;
    #2;
    d           = data_out;
    rdy         = data_ready;
    data_read_n = 2'b11;
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_irq(input int bound, output int k);
    k = 0;
    while (user_interrupt !== 1'b1 && k <= bound) begin
      @(negedge clk);
      k++;
    end
  endtask

  // Returns on the first falling edge after a wrap edge
  task automatic sync_wrap(output int k);
    int tries;
    tries = 0;
    while (user_interrupt === 1'b1 && tries < 4) begin
      bus_wr(6'h04, 32'h3F, SZW);
      tries++;
    end
    wait_irq(100, k);
  endtask

  task automatic measure(input int idx, input int ncyc, output int highs, output int period,
                         output int hlen);
    logic prev, cur;
    int   first_rise, run;
    bit   in_run;
    highs = 0; period = -1; hlen = -1; first_rise = -1; run = 0; in_run = 0;
    prev  = uo_out[idx];
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      cur = uo_out[idx];
      if (cur) highs++;
      if (cur && !prev) begin
        if (first_rise < 0) first_rise = i;
        else if (period < 0) period = i - first_rise;
        in_run = 1; run = 0;
      end
      if (in_run) begin
        if (cur) run++;
        else begin
          if (hlen < 0) hlen = run;
          in_run = 0;
        end
      end
      prev = cur;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int          hi, per, hl, k;
    logic [31:0] d;
    logic        rdy;
    bit          saw_hi;

    rst_n = 1'b0; ui_in = 8'h5A; address = '0; data_in = '0;
    data_write_n = 2'b11; data_read_n = 2'b11;
    repeat (3) @(negedge clk);

    // Reset state
    sb_push("rst_uo", 32'h0);  sb_pop(32'(uo_out));
    sb_push("rst_irq", 32'h0); sb_pop(32'(user_interrupt));
    rst_n = 1'b1;
    @(negedge clk);
    sb_push("rst_ctrl", 32'h0); bus_rd(6'h00, d, rdy); sb_pop(d);
    sb_push("rst_rdy", 32'h1);  sb_pop(32'(rdy));
    sb_push("rst_en", 32'h0);   bus_rd(6'h08, d, rdy); sb_pop(d);
    sb_push("rst_per0", 32'h0); bus_rd(6'h10, d, rdy); sb_pop(d);

    // Basic PWM on ch0: period 10, high 3
    bus_wr(6'h10, 32'd9, SZW);
    bus_wr(6'h14, 32'd3, SZW);
    bus_wr(6'h08, 32'h0101, SZW);
    bus_wr(6'h00, 32'h1, SZW);
    repeat (5) @(negedge clk);
    sb_push("pwm_highs", 32'd12); sb_push("pwm_period", 32'd10); sb_push("pwm_hlen", 32'd3);
    measure(0, 40, hi, per, hl);
    sb_pop(32'(hi)); sb_pop(32'(per)); sb_pop(32'(hl));
    sb_push("uo_upper", 32'h0); sb_pop(32'(uo_out[7:1]));
    sb_push("irq_set", 32'h1);  sb_pop(32'(user_interrupt));
    sb_push("flag_rd", 32'h1);  bus_rd(6'h04, d, rdy); sb_pop(d);

    sb_push("sync0", 32'h1); sync_wrap(k); sb_pop(32'(k <= 100));
    bus_wr(6'h04, 32'h1, SZW);
    sb_push("w1c_clear", 32'h0); sb_pop(32'(user_interrupt));
    repeat (8) @(negedge clk);
    sb_push("irq_before_wrap", 32'h0); sb_pop(32'(user_interrupt));
    @(negedge clk);
    sb_push("irq_at_wrap", 32'h1); sb_pop(32'(user_interrupt));
    bus_wr(6'h04, 32'h1, SZW);
    sb_push("w1c_clear2", 32'h0); sb_pop(32'(user_interrupt));
    repeat (8) @(negedge clk);
    bus_wr(6'h04, 32'h1, SZW);
    sb_push("w1c_vs_set_irq", 32'h1);  sb_pop(32'(user_interrupt));
    sb_push("w1c_vs_set_flag", 32'h1); bus_rd(6'h04, d, rdy); sb_pop(d);

    // Asynchronous reset while running
    rst_n = 1'b0; address = 6'h00; data_read_n = 2'b10;
    #1;
    sb_push("mr_uo", 32'h0);   sb_pop(32'(uo_out));
    sb_push("mr_irq", 32'h0);  sb_pop(32'(user_interrupt));
    sb_push("mr_ctrl", 32'h0); sb_pop(data_out);
    address = 6'h10; #1;
    sb_push("mr_per0", 32'h0); sb_pop(data_out);
    address = 6'h08; #1;
    sb_push("mr_en", 32'h0);   sb_pop(data_out);
    sb_push("mr_rdy", 32'h1);  sb_pop(32'(data_ready));
    data_read_n = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Prescaler 3, period 4 -> 20 clocks; duty 0 then duty 7
    bus_wr(6'h10, 32'd4, SZW);
    bus_wr(6'h14, 32'd0, SZW);
    bus_wr(6'h08, 32'h0101, SZW);
    bus_wr(6'h00, 32'h0301, SZW);
    repeat (3) @(negedge clk);
    sb_push("duty0_low", 32'd0); measure(0, 40, hi, per, hl); sb_pop(32'(hi));
    sb_push("sync1", 32'h1); sync_wrap(k); sb_pop(32'(k <= 100));
    bus_wr(6'h04, 32'h1, SZW);
    bus_wr(6'h14, 32'd7, SZW);
    k = 0; saw_hi = 0;
    while (user_interrupt !== 1'b1 && k <= 60) begin
      @(negedge clk);
      k++;
      if (uo_out[0]) saw_hi = 1;
    end
    sb_push("presc_wrap_dist", 32'd18); sb_pop(32'(k));
    sb_push("no_early_high", 32'd0);    sb_pop(32'(saw_hi));
    sb_push("duty_gt_per_high", 32'd40); measure(0, 40, hi, per, hl); sb_pop(32'(hi));

    // Double-buffered period update
    reset_dut();
    bus_wr(6'h10, 32'd15, SZW);
    bus_wr(6'h14, 32'd8, SZW);
    bus_wr(6'h08, 32'h0101, SZW);
    bus_wr(6'h00, 32'h1, SZW);
    sb_push("sync2", 32'h1); sync_wrap(k); sb_pop(32'(k <= 100));
    bus_wr(6'h04, 32'h1, SZW);
    bus_wr(6'h10, 32'd5, SZW);
    sb_push("dbuf_old_period", 32'd14); wait_irq(40, k); sb_pop(32'(k));
    bus_wr(6'h04, 32'h1, SZW);
    sb_push("dbuf_new_period", 32'd5);  wait_irq(40, k); sb_pop(32'(k));
    sb_push("dbuf_rd", 32'd5); bus_rd(6'h10, d, rdy); sb_pop(d);

    // One-shot on ch1
    reset_dut();
    bus_wr(6'h18, 32'd7, SZW);
    bus_wr(6'h1C, 32'd4, SZW);
    bus_wr(6'h08, 32'h0202, SZW);
    bus_wr(6'h00, 32'h0002_0001, SZW);
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (uo_out[1]) hi++;
    end
    sb_push("os_highs", 32'd4);      sb_pop(32'(hi));
    sb_push("os_en_cleared", 32'h0200); bus_rd(6'h08, d, rdy); sb_pop(d);
    sb_push("os_uo1", 32'h0);        sb_pop(32'(uo_out[1]));
    sb_push("os_flag", 32'h2);       bus_rd(6'h04, d, rdy); sb_pop(d);
    sb_push("os_irq", 32'h1);        sb_pop(32'(user_interrupt));
    bus_wr(6'h04, 32'h2, SZW);
    repeat (20) @(negedge clk);
    sb_push("os_single_wrap", 32'h0); bus_rd(6'h04, d, rdy); sb_pop(d);

    // Access sizes and unmapped addresses
    reset_dut();
    bus_wr(6'h20, 32'h0000_1234, SZW);
    bus_wr(6'h20, 32'hDEAD_BEAB, SZB);
    sb_push("byte_wr", 32'h12AB);      bus_rd(6'h20, d, rdy); sb_pop(d);
    sb_push("addr_lsb_ign", 32'h12AB); bus_rd(6'h22, d, rdy); sb_pop(d);
    bus_wr(6'h08, 32'hFFFF_FFFF, SZH);
    sb_push("half_en", 32'h0F0F);      bus_rd(6'h08, d, rdy); sb_pop(d);
    sb_push("unmapped_3c", 32'h0);     bus_rd(6'h3C, d, rdy); sb_pop(d);
    sb_push("unmapped_rdy", 32'h1);    sb_pop(32'(rdy));
    sb_push("unmapped_0c", 32'h0);     bus_rd(6'h0C, d, rdy); sb_pop(d);
    bus_wr(6'h2C, 32'hFFFF_FFFF, SZW);
    sb_push("duty3_width", 32'hFFFF);  bus_rd(6'h2C, d, rdy); sb_pop(d);
    bus_wr(6'h00, 32'hFFFF_FFFF, SZW);
    sb_push("ctrl_word", 32'h000F_FF01); bus_rd(6'h00, d, rdy); sb_pop(d);

    check_val("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
